// File: rtl/fact_host_if.sv
// -----------------------------------------------------------------------------
// fact_host_if
//
// Bus-side initiator for the FSM factorial/multiply accelerator. Software sees
// four word registers on the data bus (operand, control, status, result). A go
// write launches one accelerator run: acc_go is pulsed for a single cycle and
// the block then waits for acc_done, guarded by a watchdog. The outcome is
// latched into sticky status bits plus a result register for polling, and an
// optional level interrupt.
//
// Ports:
//   CLK        in   system clock, all state on the rising edge
//   RST        in   asynchronous active-low reset
//   A          in   register select: 0 operand, 1 control, 2 status, 3 result
//   WE         in   bus write strobe
//   WD         in   bus write data
//   RD         out  bus read data, combinational on A
//   acc_d      out  operand to accelerator D (mirror of the operand register)
//   acc_go     out  single-cycle GO pulse to accelerator
//   acc_done   in   accelerator done
//   acc_error  in   accelerator error (operand out of range)
//   acc_out    in   accelerator result
//   irq        out  level interrupt: status.done & ctrl.ie
//
// Control register (A=1) write bits: 0 go (strobe), 1 ie (stored), 2 clr.
// Status register (A=2) read bits:   0 done, 1 error, 2 timeout, 3 busy.
// -----------------------------------------------------------------------------
module fact_host_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            A,
  input  logic                  WE,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic [DATA_WIDTH-1:0] acc_d,
  output logic                  acc_go,
  input  logic                  acc_done,
  input  logic                  acc_error,
  input  logic [DATA_WIDTH-1:0] acc_out,
  output logic                  irq
);

  localparam int                WDOG_W    = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   operand_q, operand_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    ie_q, ie_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    timeout_q, timeout_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  // Set after one idle cycle in FLUSH; a second idle cycle ends the flush.
  logic                    flush_q, flush_d;

  logic busy;
  logic wr_operand;
  logic wr_ctrl;
  logic go_accept;
  logic clr_req;
  logic acc_finish;
  logic wdog_expired;

  // ---------------------------------------------------------------------------
  // Bus write decode and run events
  // ---------------------------------------------------------------------------
  assign wr_operand   = WE && (A == 2'd0);
  assign wr_ctrl      = WE && (A == 2'd1);
  assign go_accept    = wr_ctrl && WD[0] && (state_q == S_IDLE);
  assign clr_req      = wr_ctrl && WD[2];
  assign acc_finish   = (state_q == S_WAIT) && acc_done;
  // A done in the same cycle as the last watchdog count wins over the timeout.
  assign wdog_expired = (state_q == S_WAIT) && !acc_done && (wdog_q == WDOG_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (go_accept) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done) begin
          state_d = S_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Wait out a late done (discarded) or two quiet cycles.
        if (acc_done || flush_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_go = (state_q == S_START);
    busy   = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    operand_d = operand_q;
    ie_d      = ie_q;
    result_d  = result_q;
    done_d    = done_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    wdog_d    = wdog_q;
    flush_d   = (state_q == S_FLUSH) && !acc_done;

    // Operand is frozen while a run is in flight.
    if (wr_operand && !busy) begin
      operand_d = WD;
    end

    if (wr_ctrl) begin
      ie_d = WD[1];
    end

    // Watchdog: cleared in START, counts in WAIT, saturates at its last value.
    if (state_q == S_START) begin
      wdog_d = '0;
    end else if ((state_q == S_WAIT) && (wdog_q != WDOG_LAST)) begin
      wdog_d = wdog_q + 1'b1;
    end

    // Sticky bits: a clear or an accepted go wipes them first; a completion
    // in the same cycle is applied on top so it is never lost.
    if (clr_req || go_accept) begin
      done_d    = 1'b0;
      error_d   = 1'b0;
      timeout_d = 1'b0;
    end

    if (acc_finish) begin
      result_d = acc_out;
      done_d   = 1'b1;
      error_d  = acc_error;
    end else if (wdog_expired) begin
      done_d    = 1'b1;
      timeout_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      operand_q <= '0;
      ie_q      <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
      flush_q   <= 1'b0;
    end else begin
      operand_q <= operand_d;
      ie_q      <= ie_d;
      result_q  <= result_d;
      done_q    <= done_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
      flush_q   <= flush_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus read mux (side-effect free) and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    RD = '0;
    case (A)
      2'd0: RD = operand_q;
      2'd1: RD = {{(DATA_WIDTH-2){1'b0}}, ie_q, 1'b0};
      2'd2: RD = {{(DATA_WIDTH-4){1'b0}}, busy, timeout_q, error_q, done_q};
      2'd3: RD = result_q;
      default: RD = '0;
    endcase
  end

  assign acc_d = operand_q;
  assign irq   = done_q & ie_q;

endmodule
